shift_register_collect: RTL

//  Radix-4 result collector: the write-side counterpart of the digit-consuming

---
 rtl/shift_register_collect_if.sv | 28 ++
 rtl/shift_register_collect.sv | 86 ++++++++
 2 files changed

// File: rtl/shift_register_collect_if.sv
// Handshake bundle for the radix-2^DIGIT result collector: digit input side,
// assembled-number output side, and the start/ack controls.
interface shift_register_collect_if #(
  parameter int WIDTH = 1028,
  parameter int DIGIT = 2
);
  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = $clog2(NDIG + 1);

  logic             start;
  logic [DIGIT-1:0] in_digit;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_number;
  logic             out_valid;
  logic             out_ack;
  logic [CW-1:0]    digit_count;

  modport master (
    output start, in_digit, in_valid, out_ack,
    input  in_ready, out_number, out_valid, digit_count
  );

  modport slave (
    input  start, in_digit, in_valid, out_ack,
    output in_ready, out_number, out_valid, digit_count
  );
endinterface

// File: rtl/shift_register_collect.sv
// Collects NDIG LSB-first digits into a WIDTH-bit number by shifting in from the top;
// out_valid rises one cycle after the last accept and holds until out_ack or start.
module shift_register_collect #(
  parameter int WIDTH = 1028,
  parameter int DIGIT = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  shift_register_collect_if.slave  bus
);
  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = $clog2(NDIG + 1);

  if (WIDTH % DIGIT != 0) begin : g_bad_width
    $error("shift_register_collect: WIDTH must be a multiple of DIGIT");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_FULL
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] num_q, num_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             accept;

  assign accept = in_ready_q & bus.in_valid;

  always_comb begin
    state_d = state_q;
    num_d   = num_q;
    cnt_d   = cnt_q;
    // start overrides everything, including a digit offered in the same cycle
    if (bus.start) begin
      num_d   = '0;
      cnt_d   = '0;
      state_d = S_COLLECT;
    end else begin
      case (state_q)
        S_COLLECT: begin
          if (accept) begin
            num_d = {bus.in_digit, num_q[WIDTH-1:DIGIT]};
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(NDIG - 1)) begin
              state_d = S_FULL;
            end
          end
        end
        S_FULL: begin
          if (bus.out_ack) begin
            state_d = S_IDLE;
          end
        end
        default: begin
        end
      endcase
    end
    in_ready_d  = (state_d == S_COLLECT);
    out_valid_d = (state_d == S_FULL);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      num_q       <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      num_q       <= num_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_number  = num_q;
  assign bus.digit_count = cnt_q;
endmodule
